// File: rtl/contador_gray_pkg.sv
// Shared defaults and direction encoding for the parameterised Gray counter.
package contador_gray_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 5;
  localparam int unsigned CNT_RESET_DEF = 0;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : contador_gray_pkg

// File: rtl/bin2gray.sv
// Combinational binary-to-reflected-Gray converter.
module bin2gray #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray_c
);

  assign o_gray_c = i_bin ^ (i_bin >> 1);

endmodule : bin2gray

// File: rtl/contador_gray_param.sv
// Up/down counter with registered binary and Gray outputs plus wrap pulse.
// Optional synchronous load is compiled in with CONTADOR_GRAY_LOAD_EN.
module contador_gray_param
  import contador_gray_pkg::*;
#(
  parameter int unsigned WIDTH       = CNT_WIDTH_DEF,
  parameter int unsigned RESET_VALUE = CNT_RESET_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_tc;
  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;
  logic             w_tc_nxt;

  // Next count; a later load assignment overrides the enabled step.
  always_comb begin
    w_bin_nxt = r_bin;
    w_tc_nxt  = 1'b0;
    if (enable) begin
      if (up_down == DIR_UP) begin
        w_bin_nxt = r_bin + WIDTH'(1);
        w_tc_nxt  = (r_bin == '1);
      end else begin
        w_bin_nxt = r_bin - WIDTH'(1);
        w_tc_nxt  = (r_bin == '0);
      end
    end
`ifdef CONTADOR_GRAY_LOAD_EN
    if (load) begin
      w_bin_nxt = load_value;
      w_tc_nxt  = 1'b0;
    end
`endif
  end

`ifndef CONTADOR_GRAY_LOAD_EN
  logic w_unused_load;
  assign w_unused_load = ^{load, load_value};
`endif

  bin2gray #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .i_bin    (w_bin_nxt),
    .o_gray_c (w_gray_nxt)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_bin  <= RST_BIN;
      r_gray <= RST_GRAY;
      r_tc   <= 1'b0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
      r_tc   <= w_tc_nxt;
    end
  end

  assign bin_out  = r_bin;
  assign data_out = r_gray;
  assign tc       = r_tc;

endmodule : contador_gray_param

// File: doc/contador_gray_param.md
CONTADOR_GRAY_PARAM -- requirements
Module: contador_gray_param

Interface
REQ-001 Parameter WIDTH, default 5, counter width in bits; legal range 2..16.
REQ-002 Parameter RESET_VALUE, default 0, binary count value loaded on reset.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset_L  input  1  reset, asynchronous, active-low.
REQ-005 Port enable  input  1  advance the count one step on this edge when high.
REQ-006 Port up_down  input  1  count direction: 1 = up (+1), 0 = down (-1).
REQ-007 Port load  input  1  synchronous load request.
REQ-008 Port load_value  input  WIDTH  binary value to load.
REQ-009 Port data_out  output  WIDTH  registered Gray-coded count.
REQ-010 Port bin_out  output  WIDTH  registered binary count, always consistent with data_out.
REQ-011 Port tc  output  1  registered terminal-count pulse.

Function
REQ-012 The block SHALL hold the state in registers; data_out SHALL equal bin_out ^ (bin_out >> 1) in every cycle, driven directly from flops with no combinational path from inputs.
REQ-013 Edge priority SHALL be: reset, then load, then enable, then hold.
REQ-014 With load=0, enable=1, up_down=1: bin_out <= bin_out + 1 modulo 2^WIDTH; 1-cycle latency.
REQ-015 With load=0, enable=1, up_down=0: bin_out <= bin_out - 1 modulo 2^WIDTH; 1-cycle latency.
REQ-016 With load=0, enable=0: bin_out, data_out hold; tc <= 0.
REQ-017 Each enabled step, including wrap-around, SHALL change exactly one bit of data_out.
REQ-018 tc SHALL be 1 for exactly the cycle after an edge where the count wrapped (up from all-ones to 0, or down from 0 to all-ones), else 0.
REQ-019 up_down changes SHALL take effect on the same edge, with no dead cycle.

Reset
REQ-020 On reset_L=0, without waiting for clk: bin_out = RESET_VALUE, data_out = Gray(RESET_VALUE), tc = 0.
REQ-021 Reset asserted mid-count SHALL discard any pending step or load.
REQ-022 The first edge after reset_L rises SHALL obey REQ-013..REQ-016 normally.

Configuration
REQ-023 Macro CONTADOR_GRAY_LOAD_EN: when defined, load and load_value act as REQ-013; on a load edge, bin_out <= load_value, data_out <= Gray(load_value), tc <= 0, and enable/up_down are ignored.
REQ-024 When CONTADOR_GRAY_LOAD_EN is undefined, the ports remain, their values are ignored, and no load logic is synthesised.

Structure
REQ-025 A shared package contador_gray_pkg SHALL hold the default WIDTH (5), default RESET_VALUE (0) and the up/down direction constants.
REQ-026 Binary-to-Gray conversion SHALL live in one combinational sub-module bin2gray, parameterised by WIDTH, and the next-state Gray value SHALL use it.
REQ-027 The design SHALL synthesise with the team's standard flow and CMOS cell library, and the gate-level netlist SHALL match RTL cycle-for-cycle.

Verification (WIDTH=5 unless stated; RTL and synthesised netlist run side by side with outputs compared every cycle)
REQ-028 Count up from reset with enable=1 for 31 edges -> data_out 00000,00001,00011,00010,... ending at 10000 (bin 31); the next edge gives 00000 with tc=1 for one cycle.
REQ-029 With bin_out=0, up_down=0, enable=1 -> data_out=10000, bin_out=11111, tc=1 for one cycle.
REQ-030 Pulse reset_L low between edges at count 13 -> outputs go to 00000 and tc=0 before the next edge.
REQ-031 With the macro defined, load=1, load_value=10101, enable=1, up_down=0 -> bin_out=10101, data_out=11111, tc=0; without the macro the count decrements instead.
REQ-032 enable=0 for 10 cycles at count 7 -> data_out stays 00100 and tc stays 0.
REQ-033 WIDTH=3 instance counting up for 8 enabled edges -> returns to 000 with exactly one data_out bit change per step and tc=1 after the wrap.
